// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the instruction memory combinationally
// and queues {pc, instr} pairs for decode behind a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] read_address,
  input  logic [31:0] instruction_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misaligned_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic          r_mis;
  logic [31:0]   r_q_pc    [FIFO_DEPTH];
  logic [31:0]   r_q_instr [FIFO_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // A redirect flushes the queue, so the head is not consumed that cycle.
  assign w_pop   = ~w_empty & if_ready & ~redirect_valid;
  assign w_push  = fetch_en & ~redirect_valid & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_mis   <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_target[31:2], 2'b00};
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      if (redirect_target[1:0] != 2'b00) r_mis <= 1'b1;
    end else begin
      if (w_push) begin
        r_pc <= r_pc + 32'd4;
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_q_pc[r_wr]    <= r_pc;
      r_q_instr[r_wr] <= instruction_out;
    end
  end

  assign read_address   = r_pc;
  assign if_valid       = ~w_empty;
  assign if_pc          = w_empty ? 32'd0 : r_q_pc[r_rd];
  assign if_instr       = w_empty ? 32'd0 : r_q_instr[r_rd];
  assign misaligned_err = r_mis;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side master of the instruction memory.
- Owns the program counter and drives the memory word address.
- Captures the combinationally returned instruction word into a small in-order fetch queue.
- Presents {pc, instruction} pairs to decode over a valid/ready handshake; branch/jump redirects flush the queue and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, fetch queue entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  permits new fetches when high; queued entries still drain when low.
- read_address  output  32  byte address to instruction memory; always equal to current PC.
- instruction_out  input  32  instruction word returned combinationally for read_address in the same cycle.
- redirect_valid  input  1  branch/jump taken; load PC from redirect_target.
- redirect_target  input  32  new fetch byte address.
- if_valid  output  1  queue head holds a valid fetched instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_pc  output  32  PC of the head entry; 0 when if_valid=0.
- if_instr  output  32  instruction of the head entry; 0 when if_valid=0.
- misaligned_err  output  1  sticky: set when a redirect target had bits[1:0]!=0.

Behaviour:
- Reset (clk edge with reset=1):
  - pc<=RESET_PC, count<=0, rd/wr pointers<=0, misaligned_err<=0.
  - Hence if_valid=0, if_pc=0, if_instr=0, read_address=RESET_PC.
  - Reset dominates every other input, including mid-stream: the queue is discarded and the PC is reloaded.
- Queue state:
  - count, 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- pop = if_valid & if_ready.
- push = fetch_en & ~redirect_valid & (~full | pop).
  - Pushing into a full queue in the same cycle as a pop is legal; count is unchanged.
  - A push writes {pc, instruction_out} at the write pointer.
  - pc<=pc+4 on push (32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000).
  - On no push the PC holds.
- Redirect (redirect_valid=1), highest priority after reset:
  - Flush: count<=0, pointers<=0.
  - No push or pop that cycle; the head is not considered consumed even if if_ready=1.
  - pc<={redirect_target[31:2],2'b00}.
  - If redirect_target[1:0]!=0: misaligned_err<=1, cleared only by reset.
- Latency:
  - An instruction fetched in cycle N appears at if_valid in cycle N+1.
  - After a redirect in cycle N: read_address=target in N+1, if_valid with if_pc=target in N+2.
  - Sustained throughput is 1 instruction/cycle with if_ready held high.
- Ordering: strictly in PC order; no entry is dropped or duplicated except via flush.
- if_valid = ~empty; if_pc/if_instr driven from the head entry, forced to 0 when empty.
- Backpressure: if_ready=0 with fetch_en=1 fills the queue to FIFO_DEPTH, then the PC freezes.
  - read_address stays at the next unfetched PC until space frees.
- fetch_en=0: PC holds and the queue drains normally. Re-asserting fetch_en resumes at the held PC.
- Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset release, fetch_en=1, if_ready=1, memory returning word = address:
  - if_valid rises one cycle after the first unreset edge.
  - if_pc sequence 0,4,8,12 on consecutive cycles; if_instr equals if_pc.
- if_ready=0 for 5 cycles from PC 0:
  - Queue holds PCs 0 and 4; read_address frozen at 8; if_pc stays 0.
  - After if_ready=1: outputs 0,4,8 back-to-back with no gap or duplicate.
- Redirect to 32'h40 while queue holds PCs 8 and 12 and if_ready=1:
  - Next cycle if_valid=0, read_address=32'h40.
  - Following cycle if_pc=32'h40; PCs 8 and 12 are never accepted.
- Redirect target 32'h2E:
  - pc becomes 32'h2C and misaligned_err=1.
  - misaligned_err stays 1 through a later aligned redirect; it clears only on reset.
- Reset asserted while the queue is full and a redirect is pending:
  - Next cycle if_valid=0, read_address=RESET_PC, misaligned_err=0.
- Wrap case: RESET_PC=32'hFFFF_FFF8, free-running fetch gives if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
